invader_grid: RTL
=================

Name: invader_grid

Overview:
- Downstream consumer of the invader-movement block's topLeftX/topLeftY; owns the ROWS x COLS invader formation.
- Per pixel: decides whether the current VGA pixel falls on a live invader and gives the bitmap offset for the drawer.
- Keeps the alive bitmap, which is updated by missile hits.
- Produces the feedback the movement block consumes: a direction-aware chgDir pulse, plus reachedBottom and allDead for game control.

Parameters:
- COLS, 8, invaders per row.
- ROWS, 4, invader rows.
- PITCH_X, 64, horizontal cell pitch in pixels; must be a power of 2.
- PITCH_Y, 32, vertical cell pitch in pixels; must be a power of 2.
- INV_W, 32, invader sprite width in pixels (INV_W <= PITCH_X).
- INV_H, 16, invader sprite height in pixels (INV_H <= PITCH_Y).
- RIGHT_LIMIT, 632, pixel X that the rightmost live invader's right edge must not pass.
- LEFT_LIMIT, 8, pixel X that the leftmost live invader's left edge must not pass.
- BOTTOM_Y, 440, pixel Y that counts as invasion when reached.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset; synchronous, active-high (asserted = 1); name kept per codebase.
- startOfFrame  in  1  one-cycle pulse at frame start.
- pixelX  in  11  current VGA pixel X.
- pixelY  in  11  current VGA pixel Y.
- topLeftX  in  11  formation top-left X, from the movement block.
- topLeftY  in  11  formation top-left Y, from the movement block.
- hit  in  1  collision pulse; refers to the pixel currently flagged by drawingRequest.
- newLevel  in  1  one-cycle pulse; revives all invaders.
- drawingRequest  out  1  registered; pixel lies on a live invader.
- offsetX  out  11  registered; X within the sprite, 0..INV_W-1.
- offsetY  out  11  registered; Y within the sprite, 0..INV_H-1.
- rowIdx  out  3  registered; row of the drawn invader (selects sprite bitmap).
- aliveCount  out  6  number of live invaders.
- allDead  out  1  level; aliveCount == 0.
- chgDir  out  1  one-cycle pulse to the movement block.
- reachedBottom  out  1  sticky invasion flag.

Behaviour:
- Reset (resetN=1 at a clk edge): all alive bits = 1; aliveCount = ROWS*COLS; dirRight = 1; armed = 1; prevX = topLeftX.
- Reset also clears, to 0: drawingRequest, offsetX, offsetY, rowIdx, chgDir, reachedBottom, allDead.
- Pixel path:
  - relX = pixelX - topLeftX and relY = pixelY - topLeftY, computed 12-bit signed.
  - Pixel is inside the grid iff 0 <= relX < COLS*PITCH_X and 0 <= relY < ROWS*PITCH_Y.
  - col = relX / PITCH_X and row = relY / PITCH_Y, by shift only.
  - inSprite iff (relX mod PITCH_X) < INV_W and (relY mod PITCH_Y) < INV_H.
- Pixel outputs are registered with 1-cycle latency from pixelX/Y. A cell index register (row*COLS+col) is captured alongside drawingRequest.
- drawingRequest = inside & inSprite & alive[row][col]. Outside the grid, drawingRequest = 0 and the offsets are don't-care.
- Hit handling:
  - If hit=1 while drawingRequest=1, clear the alive bit at the registered cell index next cycle and decrement aliveCount by 1.
  - If hit=1 while drawingRequest=0, or the cell is already dead, nothing changes.
  - Each hit pulse kills at most one invader; multiple hits in one frame are all honoured.
- newLevel=1: all alive bits = 1, aliveCount = ROWS*COLS, reachedBottom cleared. newLevel wins over a simultaneous hit.
- Extents: leftCol, rightCol and bottomRow of the live invaders are computed combinationally from the alive bitmap by priority scan.
- Direction tracking, on each startOfFrame:
  - If topLeftX > prevX, set dirRight=1; if topLeftX < prevX, set dirRight=0; if equal, dirRight is unchanged.
  - prevX <= topLeftX.
  - If dirRight changed value, set armed=1.
- chgDir (pulses only on the cycle after startOfFrame, and only if armed=1 and allDead=0):
  - Moving right: pulse if topLeftX + rightCol*PITCH_X + INV_W >= RIGHT_LIMIT.
  - Moving left: pulse if topLeftX + leftCol*PITCH_X <= LEFT_LIMIT.
  - On a pulse, armed is cleared, so there is exactly one pulse per edge approach.
- reachedBottom: set when topLeftY + bottomRow*PITCH_Y + INV_H >= BOTTOM_Y is true at startOfFrame with allDead=0. Stays set until reset or newLevel.
- allDead is registered and equals (aliveCount == 0).
- Reset mid-frame: all state is restored on the next edge; pixel outputs read 0 for one cycle.

Test Plan:
1. Reset, topLeft=(20,20), pixel=(20,20) -> next cycle drawingRequest=1, offsetX=0, offsetY=0, rowIdx=0. Pixel=(52,20) -> drawingRequest=0 (gap column).
2. Pixel=(84,52) with hit=1 in the drawingRequest cycle (cell row1 col1) -> aliveCount 32->31. The same pixel in the next frame gives drawingRequest=0; a second hit there leaves aliveCount=31.
3. topLeftX stepping 100,101,102… across frames -> chgDir pulses once on the startOfFrame where topLeftX+7*64+32 >= 632 (topLeftX=152). No repeat pulse until topLeftX decreases.
4. Kill all of column 7 -> the right-edge trigger moves to topLeftX=216. Moving left, the pulse fires at topLeftX <= 8.
5. topLeftY driven to 328 (row 3 bottom = 328+96+16 = 440) -> reachedBottom=1 at that startOfFrame and stays 1. newLevel -> reachedBottom=0, aliveCount=32.
6. 32 valid hits -> aliveCount=0, allDead=1, chgDir never pulses. newLevel and hit in the same cycle -> aliveCount=32.

Source files
------------

// File: rtl/invader_grid_if.sv
// invader_grid_if: pixel, formation position, hit and status signals between invader_grid and its neighbours
interface invader_grid_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        hit;
  logic        newLevel;
  logic        drawingRequest;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [2:0]  rowIdx;
  logic [5:0]  aliveCount;
  logic        allDead;
  logic        chgDir;
  logic        reachedBottom;
  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY, hit, newLevel,
    input  drawingRequest, offsetX, offsetY, rowIdx, aliveCount, allDead, chgDir, reachedBottom
  );
  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY, hit, newLevel,
    output drawingRequest, offsetX, offsetY, rowIdx, aliveCount, allDead, chgDir, reachedBottom
  );
endinterface

// File: rtl/invader_grid.sv
// invader_grid: invader formation draw/hit/edge logic; ports clk, resetN (sync active-high), bus (slave: pixel/topLeft/hit/newLevel in; draw/offset/row/count/chgDir/reachedBottom out)
module invader_grid #(
  parameter int COLS        = 8,
  parameter int ROWS        = 4,
  parameter int PITCH_X     = 64,
  parameter int PITCH_Y     = 32,
  parameter int INV_W       = 32,
  parameter int INV_H       = 16,
  parameter int RIGHT_LIMIT = 632,
  parameter int LEFT_LIMIT  = 8,
  parameter int BOTTOM_Y    = 440
) (
  input logic           clk,
  input logic           resetN,
  invader_grid_if.slave bus
);
  localparam int N   = ROWS * COLS;
  localparam int SX  = $clog2(PITCH_X);
  localparam int SY  = $clog2(PITCH_Y);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CIW = $clog2(N);
  logic signed [11:0] w_rel_x, w_rel_y;
  logic [CW-1:0]      w_col, w_left, w_right;
  logic [RW-1:0]      w_row, w_bot;
  logic [CIW-1:0]     w_cell;
  logic               w_in, w_spr, w_draw, w_kill;
  logic [COLS-1:0]    w_col_any;
  logic [ROWS-1:0]    w_row_any;
  logic [N-1:0]       w_alive_nxt;
  logic [5:0]         w_count_nxt;
  logic               w_dir_nxt, w_armed, w_edge_r, w_edge_l, w_fire, w_bot_hit;
  logic [N-1:0]       r_alive;
  logic [CIW-1:0]     r_cell;
  logic [5:0]         r_count;
  logic [10:0]        r_prev_x, r_off_x, r_off_y;
  logic [2:0]         r_row;
  logic               r_draw, r_dir, r_armed, r_chg, r_bottom, r_all_dead;
  assign w_rel_x = $signed({1'b0, bus.pixelX}) - $signed({1'b0, bus.topLeftX});
  assign w_rel_y = $signed({1'b0, bus.pixelY}) - $signed({1'b0, bus.topLeftY});
  assign w_in    = !w_rel_x[11] && (w_rel_x[10:0] < 11'(COLS * PITCH_X)) &&
                   !w_rel_y[11] && (w_rel_y[10:0] < 11'(ROWS * PITCH_Y));
  assign w_col   = w_rel_x[SX +: CW];
  assign w_row   = w_rel_y[SY +: RW];
  assign w_cell  = CIW'(w_row) * CIW'(COLS) + CIW'(w_col);
  assign w_spr   = ({1'b0, w_rel_x[SX-1:0]} < (SX+1)'(INV_W)) && ({1'b0, w_rel_y[SY-1:0]} < (SY+1)'(INV_H));
  assign w_draw  = w_in && w_spr && r_alive[w_cell];
  // r_draw was sampled a cycle earlier, so re-check the bit to ignore a cell already killed
  assign w_kill      = bus.hit && r_draw && r_alive[r_cell];
  always_comb begin
    w_alive_nxt = r_alive;
    if (w_kill) w_alive_nxt[r_cell] = 1'b0;
    w_alive_nxt = bus.newLevel ? {N{1'b1}} : w_alive_nxt;
    w_count_nxt = bus.newLevel ? 6'(N) : w_kill ? r_count - 6'd1 : r_count;
  end
  always_comb begin
    w_col_any = '0;
    w_row_any = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r_alive[r*COLS+c]) begin
          w_col_any[c] = 1'b1;
          w_row_any[r] = 1'b1;
        end
    w_left  = '0;
    w_right = '0;
    w_bot   = '0;
    for (int c = COLS - 1; c >= 0; c--) if (w_col_any[c]) w_left = CW'(c);
    for (int c = 0; c < COLS; c++) if (w_col_any[c]) w_right = CW'(c);
    for (int r = 0; r < ROWS; r++) if (w_row_any[r]) w_bot = RW'(r);
  end
  // edge tests use the direction as updated by this frame's motion
  assign w_dir_nxt = (bus.topLeftX > r_prev_x) ? 1'b1 : (bus.topLeftX < r_prev_x) ? 1'b0 : r_dir;
  assign w_armed   = r_armed || (w_dir_nxt != r_dir);
  assign w_edge_r  = ({2'b0, bus.topLeftX} + 13'({w_right, {SX{1'b0}}}) + 13'(INV_W)) >= 13'(RIGHT_LIMIT);
  assign w_edge_l  = ({2'b0, bus.topLeftX} + 13'({w_left, {SX{1'b0}}})) <= 13'(LEFT_LIMIT);
  assign w_fire    = bus.startOfFrame && w_armed && !r_all_dead && (w_dir_nxt ? w_edge_r : w_edge_l);
  assign w_bot_hit = ({2'b0, bus.topLeftY} + 13'({w_bot, {SY{1'b0}}}) + 13'(INV_H)) >= 13'(BOTTOM_Y);
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_alive    <= {N{1'b1}};
      r_count    <= 6'(N);
      r_dir      <= 1'b1;
      r_armed    <= 1'b1;
      r_prev_x   <= bus.topLeftX;
      r_draw     <= 1'b0;
      r_off_x    <= '0;
      r_off_y    <= '0;
      r_row      <= '0;
      r_cell     <= '0;
      r_chg      <= 1'b0;
      r_bottom   <= 1'b0;
      r_all_dead <= 1'b0;
    end else begin
      r_draw     <= w_draw;
      r_off_x    <= 11'(w_rel_x[SX-1:0]);
      r_off_y    <= 11'(w_rel_y[SY-1:0]);
      r_row      <= 3'(w_row);
      r_cell     <= w_cell;
      r_alive    <= w_alive_nxt;
      r_count    <= w_count_nxt;
      r_all_dead <= w_count_nxt == 6'd0;
      r_chg      <= w_fire;
      if (bus.startOfFrame) begin
        r_dir    <= w_dir_nxt;
        r_prev_x <= bus.topLeftX;
        r_armed  <= w_armed && !w_fire;
      end
      if (bus.newLevel) r_bottom <= 1'b0;
      else if (bus.startOfFrame && w_bot_hit && !r_all_dead) r_bottom <= 1'b1;
    end
  end
  assign bus.drawingRequest = r_draw;
  assign bus.offsetX        = r_off_x;
  assign bus.offsetY        = r_off_y;
  assign bus.rowIdx         = r_row;
  assign bus.aliveCount     = r_count;
  assign bus.allDead        = r_all_dead;
  assign bus.chgDir         = r_chg;
  assign bus.reachedBottom  = r_bottom;
endmodule
